// File: rtl/param_updown_counter_hex_pkg.sv
// Shared display constants for the counter and later display blocks.
// Seven-segment codes are active-low, bit 6 = segment a ... bit 0 = segment g.
package param_updown_counter_hex_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/param_updown_counter_hex_seg7_digit.sv
// Hex nibble to active-low seven-segment decode (pure combinational).
// Ports: nibble - 4-bit value; seg - segments a..g on bits 6..0, 0 = lit.
module seg7_digit
    import param_updown_counter_hex_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/param_updown_counter_hex.sv
// Modulo-MOD up/down counter with clamped parallel load, cascade terminal
// count, sticky wrap flag and direct hex seven-segment drive.
// Ports: Clock, Resetn (sync, active-low), En, Up, Load, LoadVal[WIDTH];
//        Count[WIDTH] (reg), Tc (comb), Ovf (reg), HEX[DIGITS*7] (comb, active-low).
module param_updown_counter_hex
    import param_updown_counter_hex_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter longint unsigned  MOD   = 256
)(
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      En,
    input  logic                      Up,
    input  logic                      Load,
    input  logic [WIDTH-1:0]          LoadVal,
    output logic [WIDTH-1:0]          Count,
    output logic                      Tc,
    output logic                      Ovf,
    output logic [((WIDTH+3)/4)*7-1:0] HEX
);

    localparam int unsigned     DIGITS  = (WIDTH + 3) / 4;
    localparam int unsigned     PAD_W   = DIGITS * NIBBLE_W;
    // Top count value; the modulus is held in 64 bits so 2**32 is representable.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             at_max;
    logic             at_zero;
    logic [PAD_W-1:0] count_pad;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // Next count/flag: Load beats En; wraps are at MOD, not 2**WIDTH.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Load) begin
            count_d = (64'(LoadVal) >= MOD) ? MAX_VAL : LoadVal;
            ovf_d   = 1'b0;
        end else if (En) begin
            if (Up) begin
                if (at_max) begin
                    count_d = '0;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d = MAX_VAL;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Count = count_q;
    assign Ovf   = ovf_q;

    // Terminal count is deliberately independent of Load so cascaded stages
    // sharing Load stay coherent.
    assign Tc = En & (Up ? at_max : at_zero);

    // Zero-pad the top nibble when WIDTH is not a multiple of 4.
    assign count_pad = PAD_W'(count_q);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        seg7_digit u_digit (
            .nibble (count_pad[NIBBLE_W*i +: NIBBLE_W]),
            .seg    (HEX[SEG_W*i +: SEG_W])
        );
    end

endmodule

// File: tb/tb_param_updown_counter_hex.sv
// Directed-vector bench for param_updown_counter_hex: default-width instance,
// a decade instance (WIDTH=4, MOD=10) and a two-stage decade cascade.
module tb_param_updown_counter_hex;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Instance A: default parameters.
    logic        a_rstn, a_en, a_up, a_load, a_tc, a_ovf;
    logic [7:0]  a_lv, a_count;
    logic [13:0] a_hex;

    param_updown_counter_hex u_a (
        .Clock(Clock), .Resetn(a_rstn), .En(a_en), .Up(a_up), .Load(a_load),
        .LoadVal(a_lv), .Count(a_count), .Tc(a_tc), .Ovf(a_ovf), .HEX(a_hex)
    );

    // Instance B: decade counter.
    logic       b_rstn, b_en, b_up, b_load, b_tc, b_ovf;
    logic [3:0] b_lv, b_count;
    logic [6:0] b_hex;

    param_updown_counter_hex #(.WIDTH(4), .MOD(10)) u_b (
        .Clock(Clock), .Resetn(b_rstn), .En(b_en), .Up(b_up), .Load(b_load),
        .LoadVal(b_lv), .Count(b_count), .Tc(b_tc), .Ovf(b_ovf), .HEX(b_hex)
    );

    // Cascade: stage1 En driven by stage0 Tc, shared Load.
    logic       c_rstn, c_en, c_load;
    logic [3:0] c_lv, c0_count, c1_count;
    logic       c0_tc, c1_tc, c0_ovf, c1_ovf;
    logic [6:0] c0_hex, c1_hex;

    param_updown_counter_hex #(.WIDTH(4), .MOD(10)) u_c0 (
        .Clock(Clock), .Resetn(c_rstn), .En(c_en), .Up(1'b1), .Load(c_load),
        .LoadVal(c_lv), .Count(c0_count), .Tc(c0_tc), .Ovf(c0_ovf), .HEX(c0_hex)
    );

    param_updown_counter_hex #(.WIDTH(4), .MOD(10)) u_c1 (
        .Clock(Clock), .Resetn(c_rstn), .En(c0_tc), .Up(1'b1), .Load(c_load),
        .LoadVal(c_lv), .Count(c1_count), .Tc(c1_tc), .Ovf(c1_ovf), .HEX(c1_hex)
    );

    initial begin
        a_rstn = 1'b0; a_en = 1'b1; a_up = 1'b1; a_load = 1'b0; a_lv = 8'h00;
        b_rstn = 1'b0; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = 4'h0;
        c_rstn = 1'b0; c_en = 1'b0; c_load = 1'b0; c_lv = 4'h0;
        #1;

        // 1. Reset held two edges with En=1, then three up-counts.
        tick(2);
        check("rst_count", 64'(a_count), 64'h00);
        check("rst_ovf",   64'(a_ovf),   64'h0);
        check("rst_tc",    64'(a_tc),    64'h0);
        check("rst_hex",   64'(a_hex),   64'({7'b0000001, 7'b0000001}));
        a_rstn = 1'b1;
        tick(3);
        check("up3_count", 64'(a_count), 64'h03);

        // 2. Decade count up to 9, wrap, then ten more edges.
        b_rstn = 1'b1; b_en = 1'b1; b_up = 1'b1;
        tick(9);
        check("dec9_count", 64'(b_count), 64'd9);
        check("dec9_tc",    64'(b_tc),    64'h1);
        check("dec9_hex",   64'(b_hex),   64'(7'b0001100));
        check("dec9_ovf",   64'(b_ovf),   64'h0);
        tick(1);
        check("wrap_count", 64'(b_count), 64'd0);
        check("wrap_ovf",   64'(b_ovf),   64'h1);
        check("wrap_tc",    64'(b_tc),    64'h0);
        tick(10);
        check("wrap2_count", 64'(b_count), 64'd0);
        check("wrap2_ovf",   64'(b_ovf),   64'h1);

        // 3. Direction change at 0: Tc immediately, then underflow to 9.
        b_up = 1'b0;
        #1;
        check("dn0_tc", 64'(b_tc), 64'h1);
        tick(1);
        check("dn_count", 64'(b_count), 64'd9);
        check("dn_ovf",   64'(b_ovf),   64'h1);
        check("dn_hex",   64'(b_hex),   64'(7'b0001100));
        tick(1);
        check("dn8_count", 64'(b_count), 64'd8);
        check("dn8_hex",   64'(b_hex),   64'(7'b0000000));

        // 5. Clamped load clears Ovf; Tc ignores Load; reset beats Load.
        b_load = 1'b1; b_lv = 4'd13;
        tick(1);
        check("clamp_count", 64'(b_count), 64'd9);
        check("clamp_ovf",   64'(b_ovf),   64'h0);
        b_lv = 4'd0;
        tick(1);
        check("ld0_count", 64'(b_count), 64'd0);
        // Load still high, En=1, Up=0 at count 0: Tc must still assert.
        check("ld_tc", 64'(b_tc), 64'h1);
        b_lv = 4'd5;
        tick(1);
        check("ld5_count", 64'(b_count), 64'd5);
        check("ld5_ovf",   64'(b_ovf),   64'h0);
        b_rstn = 1'b0; b_lv = 4'd7;
        tick(1);
        check("rst_ld_count", 64'(b_count), 64'd0);
        b_rstn = 1'b1; b_load = 1'b0; b_en = 1'b0;
        tick(2);
        check("hold_count", 64'(b_count), 64'd0);

        // 4. Load overrides En/Up; 0xB6 distinguishes "6" and "b" codes.
        a_load = 1'b1; a_lv = 8'hB6; a_en = 1'b1; a_up = 1'b1;
        tick(1);
        check("ldB6_count", 64'(a_count), 64'hB6);
        check("ldB6_ovf",   64'(a_ovf),   64'h0);
        check("ldB6_hex",   64'(a_hex),   64'({7'b1100000, 7'b0100000}));
        a_lv = 8'hFF;
        tick(1);
        a_load = 1'b0;
        #1;
        check("ff_tc", 64'(a_tc), 64'h1);
        tick(1);
        check("ff_wrap_count", 64'(a_count), 64'h00);
        check("ff_wrap_ovf",   64'(a_ovf),   64'h1);
        a_up = 1'b0;
        tick(1);
        check("under_count", 64'(a_count), 64'hFF);
        check("under_ovf",   64'(a_ovf),   64'h1);
        check("under_hex",   64'(a_hex),   64'({7'b0111000, 7'b0111000}));
        a_en = 1'b0;
        tick(2);
        check("a_hold_count", 64'(a_count), 64'hFF);
        check("a_hold_tc",    64'(a_tc),    64'h0);

        // 6. Two-stage decade cascade, 99 then 100 enabled edges.
        c_rstn = 1'b1; c_en = 1'b1;
        for (int n = 1; n <= 99; n++) begin
            tick(1);
            if (n % 11 == 0) begin
                check("casc_lo", 64'(c0_count), 64'(n % 10));
                check("casc_hi", 64'(c1_count), 64'(n / 10));
            end
        end
        check("c99_lo",   64'(c0_count), 64'd9);
        check("c99_hi",   64'(c1_count), 64'd9);
        check("c99_tc",   64'(c0_tc & c1_tc), 64'h1);
        check("c99_ovf1", 64'(c1_ovf), 64'h0);
        tick(1);
        check("c100_lo",   64'(c0_count), 64'd0);
        check("c100_hi",   64'(c1_count), 64'd0);
        check("c100_ovf0", 64'(c0_ovf),   64'h1);
        check("c100_ovf1", 64'(c1_ovf),   64'h1);
        c_en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(1);
            check("c_hold", 64'({c1_count, c0_count}), 64'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
